// File: rtl/cam_reg_init_seq_if.sv
// cam_reg_init_seq_if: command/response handshake between the init sequencer and the SCCB byte master
interface cam_reg_init_seq_if;
    logic [2:0] i2c_cmd;
    logic [7:0] i2c_din;
    logic       i2c_wr;
    logic       i2c_ready;
    logic       i2c_done_tick;
    logic       i2c_ack;
    modport master (output i2c_cmd, i2c_din, i2c_wr, input i2c_ready, i2c_done_tick, i2c_ack);
    modport slave  (input i2c_cmd, i2c_din, i2c_wr, output i2c_ready, i2c_done_tick, i2c_ack);
endinterface

// File: rtl/cam_reg_init_seq.sv
// cam_reg_init_seq: walks a ROM register table and writes each entry to the camera over the SCCB byte master
module cam_reg_init_seq #(
    parameter logic [7:0]  DEV_ADDR  = 8'h42,
    parameter int          ADDR_W    = 8,
    parameter logic [23:0] DELAY_CYC = 24'd1_000_000,
    parameter int          MAX_RETRY = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [15:0]        rom_data_i,
    cam_reg_init_seq_if.master i2c,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    output logic [ADDR_W-1:0]  err_addr_o
);
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, ISSUE, POST, WAIT_DONE, WAIT_RDY, DELAY, FINISH, ERROR} state_t;
    localparam logic [23:0] DLY_LOAD = (DELAY_CYC == 24'd0) ? 24'd0 : DELAY_CYC - 24'd1;
    localparam logic [2:0] CMD_START = 3'd0, CMD_WR = 3'd1, CMD_STOP = 3'd3;
    localparam logic [2:0] ST_START = 3'd0, ST_STOP = 3'd4, ST_SENT = 3'd5;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, err_addr_q, err_addr_d;
    logic [15:0]       entry_q, entry_d;
    logic [2:0]        step_q, step_d;
    logic [7:0]        retry_q, retry_d;
    logic [23:0]       dly_q, dly_d;
    logic              nack_q, nack_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              advance;
    logic              is_wr;

    // step 0 = START, 1..3 = device/register/value bytes, 4 = STOP, 5 = STOP already strobed
    assign is_wr          = (step_q == 3'd1) || (step_q == 3'd2) || (step_q == 3'd3);
    assign i2c.i2c_wr     = (state_q == ISSUE) && i2c.i2c_ready;
    assign i2c.i2c_cmd    = (state_q != ISSUE) ? CMD_START : (step_q == ST_START) ? CMD_START :
                            (step_q == ST_STOP) ? CMD_STOP : CMD_WR;
    assign i2c.i2c_din    = (state_q != ISSUE) ? 8'd0 : (step_q == 3'd1) ? DEV_ADDR :
                            (step_q == 3'd2) ? entry_q[15:8] : (step_q == 3'd3) ? entry_q[7:0] : 8'd0;
    assign rom_addr_o     = rom_addr_q;
    assign err_addr_o     = err_addr_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;

    // Next-state logic: table walk, per-command handshake, NACK retry and start acceptance
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        err_addr_d = err_addr_q;
        entry_d    = entry_q;
        step_d     = step_q;
        retry_d    = retry_q;
        dly_d      = dly_q;
        nack_d     = nack_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        advance    = 1'b0;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                entry_d = rom_data_i;
                if (rom_data_i == 16'hFFFF) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (rom_data_i == 16'hFFF0) begin
                    dly_d   = DLY_LOAD;
                    state_d = DELAY;
                end else begin
                    step_d  = ST_START;
                    nack_d  = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (i2c.i2c_ready) state_d = is_wr ? WAIT_DONE : POST;
            POST: begin
                step_d  = step_q + 3'd1;
                state_d = WAIT_RDY;
            end
            WAIT_DONE: if (i2c.i2c_done_tick) begin
                nack_d  = i2c.i2c_ack;
                step_d  = i2c.i2c_ack ? ST_STOP : step_q + 3'd1;
                state_d = WAIT_RDY;
            end
            WAIT_RDY: if (i2c.i2c_ready) begin
                if (step_q != ST_SENT) state_d = ISSUE;
                else if (!nack_q) advance = 1'b1;
                else begin
                    retry_d = retry_q + 8'd1;
                    if (int'(retry_q) + 1 < MAX_RETRY) begin
                        step_d  = ST_START;
                        nack_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        err_addr_d = rom_addr_q;
                        error_d    = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = ERROR;
                    end
                end
            end
            DELAY: if (dly_q == 24'd0) advance = 1'b1; else dly_d = dly_q - 24'd1;
            default: ;
        endcase
        if (advance) begin
            retry_d = '0;
            if (&rom_addr_q) begin
                state_d = FINISH;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = FETCH;
            end
        end
        if (start_i && (state_q == IDLE || state_q == FINISH || state_q == ERROR)) begin
            rom_addr_d = '0;
            err_addr_d = '0;
            retry_d    = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            busy_d     = 1'b1;
            state_d    = FETCH;
        end
    end

    // State and datapath registers; reset returns straight to IDLE without touching the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            err_addr_q <= '0;
            entry_q    <= '0;
            step_q     <= '0;
            retry_q    <= '0;
            dly_q      <= '0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            err_addr_q <= err_addr_d;
            entry_q    <= entry_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            dly_q      <= dly_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end
endmodule

// File: tb/tb_cam_reg_init_seq.sv
// tb_cam_reg_init_seq: randomized bench for the camera init sequencer against a table-walk reference model
`timescale 1ns/1ps
module tb_cam_reg_init_seq;
    localparam int AW   = 4;
    localparam int NE   = 1 << AW;
    localparam int MAXR = 3;
    localparam int DLY  = 50;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [AW-1:0] rom_addr, err_addr;
    logic [15:0]   rom_data;
    logic          busy, done, error;
    logic          rdy = 1'b1, hold_low = 1'b0, bfm_busy = 1'b0, wr_prev = 1'b0;
    logic [2:0]    bc;
    logic [15:0]   rom [NE];
    int            checks = 0, failures = 0, viol = 0, cyc = 0;
    logic [10:0]   exp_q[$], log_q[$];
    int            log_t[$];
    logic          ack_q[$];
    logic          e_done, e_err;
    int            e_addr, e_ea;

    cam_reg_init_seq_if bus();
    assign bus.i2c_ready = rdy & ~hold_low;

    cam_reg_init_seq #(.DEV_ADDR(8'h42), .ADDR_W(AW), .DELAY_CYC(24'(DLY)), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .reset(reset), .start_i(start), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .i2c(bus), .busy_o(busy), .done_o(done), .error_o(error), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_data <= rom[rom_addr];

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // bus monitor: logs every strobe and flags strobes while not ready or on back-to-back cycles
    always @(negedge clk) begin
        if (bus.i2c_wr === 1'b1) begin
            if (!bus.i2c_ready || wr_prev) viol++;
            log_q.push_back({bus.i2c_cmd, bus.i2c_din});
            log_t.push_back(cyc);
        end
        wr_prev = (bus.i2c_wr === 1'b1);
    end

    // byte-master model: random latency, ack bits supplied by the reference model, stray done ticks on START/STOP
    initial begin
        bus.i2c_done_tick = 1'b0;
        bus.i2c_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.i2c_wr === 1'b1) begin
                bc = bus.i2c_cmd;
                bfm_busy = 1'b1;
                @(posedge clk);
                #1 rdy = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                if (bc == 3'd1) begin
                    bus.i2c_ack = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                    bus.i2c_done_tick = 1'b1;
                    @(posedge clk);
                    #1 bus.i2c_done_tick = 1'b0;
                    bus.i2c_ack = 1'b0;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.i2c_ack = 1'b1;
                    bus.i2c_done_tick = 1'b1;
                    @(posedge clk);
                    #1 bus.i2c_done_tick = 1'b0;
                    bus.i2c_ack = 1'b0;
                end
                rdy = 1'b1;
                bfm_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic bit want_nack(input int mode, input int pct, input int idx, input int a, input int b);
        case (mode)
            1: return idx == 0 && a == 0 && b == 1;
            2: return b == 0;
            3: return $urandom_range(0, 99) < pct;
            default: return 1'b0;
        endcase
    endfunction

    // reference: walk the table entry by entry, producing the command stream, ack bits and final status
    task automatic build(input int mode, input int pct);
        int idx = 0;
        bit fin = 0, ok, nk;
        logic [15:0] e;
        exp_q.delete();
        ack_q.delete();
        e_done = 0; e_err = 0; e_ea = 0; e_addr = 0;
        while (!fin) begin
            e = rom[idx];
            if (e == 16'hFFFF) begin
                e_done = 1; e_addr = idx; fin = 1;
            end else begin
                ok = (e == 16'hFFF0);
                for (int a = 0; !ok && !fin; a++) begin
                    exp_q.push_back({3'd0, 8'd0});
                    nk = 0;
                    for (int b = 0; b < 3 && !nk; b++) begin
                        exp_q.push_back({3'd1, (b == 0) ? 8'h42 : (b == 1) ? e[15:8] : e[7:0]});
                        nk = want_nack(mode, pct, idx, a, b);
                        ack_q.push_back(nk);
                    end
                    exp_q.push_back({3'd3, 8'd0});
                    if (!nk) ok = 1;
                    else if (a + 1 >= MAXR) begin e_err = 1; e_ea = idx; e_addr = idx; fin = 1; end
                end
                if (!fin && idx == NE - 1) begin e_done = 1; e_addr = idx; fin = 1; end
                else if (!fin) idx++;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input int mode, input int pct, input bit hold);
        int t_rel, mism;
        build(mode, pct);
        log_q.delete();
        log_t.delete();
        hold_low = hold;
        pulse_start();
        chk({tag, "_busy_on"}, busy, 1);
        if (hold) begin
            repeat (200) @(posedge clk);
            #1;
            chk({tag, "_no_wr_low"}, log_q.size(), 0);
            t_rel = cyc;
            hold_low = 1'b0;
        end
        for (int i = 0; i < 20000 && !(done || error); i++) @(posedge clk);
        chk({tag, "_finished"}, done | error, 1);
        repeat (40) @(posedge clk);
        #1;
        mism = 0;
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            if (log_q[i][10:8] != exp_q[i][10:8] || (exp_q[i][10:8] == 3'd1 && log_q[i][7:0] != exp_q[i][7:0])) mism++;
        chk({tag, "_n_strobes"}, log_q.size(), exp_q.size());
        chk({tag, "_seq_mism"}, mism, 0);
        chk({tag, "_done"}, done, e_done);
        chk({tag, "_error"}, error, e_err);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_rom_addr"}, rom_addr, e_addr);
        chk({tag, "_err_addr"}, err_addr, e_ea);
        chk({tag, "_proto_viol"}, viol, 0);
        chk({tag, "_acks_used"}, ack_q.size(), 0);
        if (hold) chk({tag, "_first_after_rel"}, log_t.size() > 0 && log_t[0] >= t_rel, 1);
    endtask

    task automatic clr_rom();
        for (int i = 0; i < NE; i++) rom[i] = 16'hFFFF;
    endtask

    initial begin
        int gap, si, len;
        reset = 1'b1;
        clr_rom();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wr", bus.i2c_wr, 0);
        reset = 1'b0;

        rom[0] = 16'h1280; rom[1] = 16'h1100;
        run("basic", 0, 0, 0);

        clr_rom();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h3A04;
        run("delay", 0, 0, 0);
        si = -1;
        for (int i = 0; i < log_q.size() && si < 0; i++) if (log_q[i][10:8] == 3'd3) si = i;
        gap = (si >= 0 && si + 1 < log_t.size()) ? log_t[si + 1] - log_t[si] : 0;
        chk("delay_gap_ge", gap >= DLY, 1);

        clr_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1100;
        run("nack_once", 1, 0, 0);
        run("nack_dev", 2, 0, 0);
        run("ready_low", 0, 0, 1);

        build(0, 0);
        log_q.delete();
        pulse_start();
        for (int i = 0; i < 2000 && log_q.size() < 9; i++) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_wr", bus.i2c_wr, 0);
        chk("midrst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 100 && bfm_busy; i++) @(posedge clk);
        #1 ack_q.delete();
        run("after_rst", 0, 0, 0);

        for (int n = 0; n < 6; n++) begin
            clr_rom();
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                rom[i] = ($urandom_range(0, 99) < 15) ? 16'hFFF0 : {8'($urandom_range(0, 239)), 8'($urandom_range(0, 255))};
            run("rand", 3, 20, 0);
        end

        for (int i = 0; i < NE; i++) rom[i] = {8'($urandom_range(0, 239)), 8'($urandom_range(0, 255))};
        run("wrap", 3, 8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
